// File: rtl/seg7_scan_scheduler_if.sv
// Requester-side bus of the seven-segment scan scheduler.
//   wr_en / wr_addr / wr_data : write one shadow digit (index 0 = leftmost)
//   commit                    : request a shadow-to-active copy at the next frame wrap
//   busy                      : a copy is pending
//   commit_done               : one-cycle pulse on the edge the copy happens
// master = requester, slave = scheduler.
interface seg7_scan_scheduler_if;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       commit;
    logic       busy;
    logic       commit_done;

    modport master (
        output wr_en, wr_addr, wr_data, commit,
        input  busy, commit_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit,
        output busy, commit_done
    );
endinterface

// File: rtl/seg7_scan_scheduler.sv
// Scan scheduler for a multiplexed 6-digit seven-segment display.
// Walks the digit select from 5 down to 6-NUM_USE, one slot per SCAN_DIV clocks,
// blanks the first DEAD clocks of every slot, and shows a double-buffered BCD store
// with optional leading-zero suppression. The active buffer is only ever reloaded
// on a frame wrap, so a frame never mixes old and new digits.
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-low reset
//   bus      : requester write/commit bus (slave side)
//   lz_en    : leading-zero suppression enable
//   disp_en  : 0 blanks every digit, scanning keeps running
//   seg7_sel : index of the digit being driven
//   bcd_out  : code for the current digit, 4'hF = blank
//
// Commit state:
//   state      | meaning
//   ST_IDLE    | no copy requested
//   ST_PENDING | copy requested, waiting for the next frame wrap (busy = 1)
module seg7_scan_scheduler #(
    parameter int NUM_USE  = 6,
    parameter int SCAN_DIV = 16,
    parameter int DEAD     = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    seg7_scan_scheduler_if.slave        bus,
    input  logic                        lz_en,
    input  logic                        disp_en,
    output logic [2:0]                  seg7_sel,
    output logic [3:0]                  bcd_out
);

    localparam int            CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int            LO_IDX  = 6 - NUM_USE;
    localparam logic [2:0]    SEL_LO  = 3'(LO_IDX);
    localparam logic [CW-1:0] PCNT_TC = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD_V  = CW'(DEAD);

    typedef enum logic {ST_IDLE, ST_PENDING} cstate_t;

    cstate_t       state;
    logic [CW-1:0] pcnt;
    logic [CW-1:0] dcnt;
    logic [3:0]    shadow [6];
    logic [3:0]    active [6];
    logic          commit_done_q;

    logic          tick;
    logic          frame_wrap;
    logic [5:0]    lz;
    logic          zrun;
    logic [3:0]    cur_val;
    logic          cur_lz;

    assign tick       = (pcnt == PCNT_TC);
    assign frame_wrap = tick && (seg7_sel == SEL_LO);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            pcnt          <= '0;
            dcnt          <= DEAD_V;
            seg7_sel      <= 3'd5;
            commit_done_q <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                shadow[i] <= 4'd0;
                active[i] <= 4'd0;
            end
        end else begin
            commit_done_q <= 1'b0;

            if (tick) begin
                pcnt     <= '0;
                dcnt     <= DEAD_V;
                seg7_sel <= frame_wrap ? 3'd5 : seg7_sel - 3'd1;
            end else begin
                pcnt <= pcnt + 1'b1;
                if (dcnt != '0) begin
                    dcnt <= dcnt - 1'b1;
                end
            end

            // Copy reads the old shadow, so a write on the copy edge waits for the next frame.
            for (int i = 0; i < 6; i++) begin
                if (bus.wr_en && (bus.wr_addr == 3'(i))) begin
                    shadow[i] <= bus.wr_data;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (bus.commit) begin
                        state <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (frame_wrap) begin
                        for (int i = 0; i < 6; i++) begin
                            active[i] <= shadow[i];
                        end
                        commit_done_q <= 1'b1;
                        // A commit landing on the wrap edge itself is held for the next wrap.
                        state <= bus.commit ? ST_PENDING : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = (state == ST_PENDING);
    assign bus.commit_done = commit_done_q;

    // Running AND of "digit is zero" from the leftmost scanned digit rightwards.
    always_comb begin
        zrun = lz_en;
        lz   = '0;
        for (int i = 0; i < 6; i++) begin
            if (i >= LO_IDX) begin
                zrun = zrun && (active[i] == 4'd0);
                if (i < 5) begin
                    lz[i] = zrun;
                end
            end
        end
    end

    always_comb begin
        cur_val = 4'd0;
        cur_lz  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (seg7_sel == 3'(i)) begin
                cur_val = active[i];
                cur_lz  = lz[i];
            end
        end
        bcd_out = (!disp_en || (dcnt != '0) || cur_lz) ? 4'hF : cur_val;
    end

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
module tb_seg7_scan_scheduler;

    localparam int SD = 4;
    localparam int DD = 1;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       commit;
    logic       lz_en;
    logic       disp_en;
    logic [2:0] sel_a, sel_b;
    logic [3:0] bcd_a, bcd_b;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt_a  = 0;

    seg7_scan_scheduler_if bus_a ();
    seg7_scan_scheduler_if bus_b ();

    assign bus_a.wr_en   = wr_en;
    assign bus_a.wr_addr = wr_addr;
    assign bus_a.wr_data = wr_data;
    assign bus_a.commit  = commit;
    assign bus_b.wr_en   = wr_en;
    assign bus_b.wr_addr = wr_addr;
    assign bus_b.wr_data = wr_data;
    assign bus_b.commit  = commit;

    seg7_scan_scheduler #(.NUM_USE(6), .SCAN_DIV(SD), .DEAD(DD)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a), .lz_en(lz_en), .disp_en(disp_en),
        .seg7_sel(sel_a), .bcd_out(bcd_a)
    );

    seg7_scan_scheduler #(.NUM_USE(4), .SCAN_DIV(SD), .DEAD(DD)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b), .lz_en(lz_en), .disp_en(disp_en),
        .seg7_sel(sel_b), .bcd_out(bcd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: time since reset decides slot and blanking; buffers are plain arrays.
    int         mk;
    int         nuse [2] = '{6, 4};
    logic [3:0] m_sh  [2][6];
    logic [3:0] m_act [2][6];
    bit         m_pend [2];
    bit         m_done [2];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mk <= 0;
            for (int u = 0; u < 2; u++) begin
                m_pend[u] <= 1'b0;
                m_done[u] <= 1'b0;
                for (int j = 0; j < 6; j++) begin
                    m_sh[u][j]  <= 4'd0;
                    m_act[u][j] <= 4'd0;
                end
            end
        end else begin
            mk <= mk + 1;
            for (int u = 0; u < 2; u++) begin
                m_done[u] <= 1'b0;
                if (((mk + 1) % (nuse[u] * SD) == 0) && m_pend[u]) begin
                    for (int j = 0; j < 6; j++) m_act[u][j] <= m_sh[u][j];
                    m_done[u] <= 1'b1;
                    m_pend[u] <= commit;
                end else if (commit) begin
                    m_pend[u] <= 1'b1;
                end
                if (wr_en && (int'(wr_addr) < 6)) m_sh[u][int'(wr_addr)] <= wr_data;
            end
        end
    end

    function automatic logic [2:0] e_sel(input int u);
        return 3'(5 - ((mk / SD) % nuse[u]));
    endfunction

    function automatic logic [3:0] e_bcd(input int u);
        int s;
        bit z;
        s = 5 - ((mk / SD) % nuse[u]);
        if (!disp_en || ((mk % SD) < DD)) return 4'hF;
        if (lz_en && s < 5) begin
            z = 1'b1;
            for (int j = 6 - nuse[u]; j <= s; j++) if (m_act[u][j] != 4'd0) z = 1'b0;
            if (z) return 4'hF;
        end
        return m_act[u][s];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, mk);
        end
    endtask

    always @(negedge clk) begin
        chk("sel_a",  32'(sel_a),             32'(e_sel(0)));
        chk("bcd_a",  32'(bcd_a),             32'(e_bcd(0)));
        chk("busy_a", 32'(bus_a.busy),        32'(m_pend[0]));
        chk("done_a", 32'(bus_a.commit_done), 32'(m_done[0]));
        chk("sel_b",  32'(sel_b),             32'(e_sel(1)));
        chk("bcd_b",  32'(bcd_b),             32'(e_bcd(1)));
        chk("busy_b", 32'(bus_b.busy),        32'(m_pend[1]));
        chk("done_b", 32'(bus_b.commit_done), 32'(m_done[1]));
        if (bus_a.commit_done === 1'b1) done_cnt_a++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_k(input int t);
        int budget;
        budget = 1000;
        while (mk < t && budget > 0) begin
            cyc();
            budget--;
        end
        if (mk != t) begin
            vectors++;
            miscompares++;
            $display("FAIL goto_k: reached cycle %0d, wanted %0d", mk, t);
        end
    endtask

    task automatic lit(input int t, input string name, input logic [31:0] act_unused);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    int dc0;

    initial begin
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 3'd0;
        wr_data = 4'd0;
        commit  = 1'b0;
        lz_en   = 1'b0;
        disp_en = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sel",  32'(sel_a), 32'd5);
        chk("rst_bcd",  32'(bcd_a), 32'hF);
        chk("rst_busy", 32'(bus_a.busy), 32'd0);
        cyc();
        reset = 1'b1;

        // First slot: dead clock, then digit; first tick on the 4th edge
        goto_k(1);  @(negedge clk); chk("k1_bcd", 32'(bcd_a), 32'h0);
        goto_k(4);  @(negedge clk); chk("k4_sel", 32'(sel_a), 32'd4);
                                    chk("k4_bcd", 32'(bcd_a), 32'hF);
        goto_k(5);  @(negedge clk); chk("k5_bcd", 32'(bcd_a), 32'h0);

        // Write 1..6, commit together with the last write while digit 3 is shown
        cyc();
        for (int i = 0; i < 6; i++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(i);
            wr_data = 4'(i + 1);
            commit  = (i == 5);
            cyc();
        end
        wr_en  = 1'b0;
        commit = 1'b0;
        @(negedge clk); chk("mid_busy",  32'(bus_a.busy), 32'd1);
                        chk("b_k12_sel", 32'(sel_b), 32'd2);
        goto_k(16); @(negedge clk); chk("b_wrap_sel",  32'(sel_b), 32'd5);
                                    chk("b_wrap_done", 32'(bus_b.commit_done), 32'd1);
        goto_k(17); @(negedge clk); chk("b_new_bcd", 32'(bcd_b), 32'h6);
        goto_k(23); @(negedge clk); chk("a_old_bcd", 32'(bcd_a), 32'h0);
                                    chk("a_pre_done", 32'(bus_a.commit_done), 32'd0);
        goto_k(24); @(negedge clk); chk("a_wrap_done", 32'(bus_a.commit_done), 32'd1);
                                    chk("a_wrap_sel",  32'(sel_a), 32'd5);
                                    chk("a_wrap_busy", 32'(bus_a.busy), 32'd0);
        goto_k(25); @(negedge clk); chk("a_new_bcd",  32'(bcd_a), 32'h6);
                                    chk("a_done_once", 32'(bus_a.commit_done), 32'd0);

        // Leading zeros: active = 0,0,1,0,0,0
        cyc();
        for (int i = 0; i < 6; i++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(i);
            wr_data = (i == 2) ? 4'd1 : 4'd0;
            commit  = (i == 5);
            cyc();
        end
        wr_en  = 1'b0;
        commit = 1'b0;
        lz_en  = 1'b1;
        goto_k(50); @(negedge clk); chk("lz_d5", 32'(bcd_a), 32'h0);
        goto_k(58); @(negedge clk); chk("lz_d3", 32'(bcd_a), 32'h0);
        goto_k(62); @(negedge clk); chk("lz_d2", 32'(bcd_a), 32'h1);
        goto_k(66); @(negedge clk); chk("lz_d1", 32'(bcd_a), 32'hF);
        goto_k(70); @(negedge clk); chk("lz_d0", 32'(bcd_a), 32'hF);

        // All zeros; commit lands on A's wrap edge (72) so it copies at 96
        cyc();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'd0; commit = 1'b1;
        cyc();
        wr_en = 1'b0; commit = 1'b0;
        @(negedge clk); chk("wrapc_done", 32'(bus_a.commit_done), 32'd0);
                        chk("wrapc_busy", 32'(bus_a.busy), 32'd1);
        // Write on the copy edge stays in the shadow
        goto_k(95);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 4'd8;
        cyc();
        wr_en = 1'b0;
        @(negedge clk); chk("wrapc_copy", 32'(bus_a.commit_done), 32'd1);
        goto_k(98);  @(negedge clk); chk("z_d5", 32'(bcd_a), 32'h0);
        goto_k(106); @(negedge clk); chk("z_d3", 32'(bcd_a), 32'hF);
        goto_k(118); @(negedge clk); chk("z_d0", 32'(bcd_a), 32'hF);

        // Suppression off
        cyc();
        lz_en = 1'b0;
        goto_k(130); @(negedge clk); chk("nolz_d3", 32'(bcd_a), 32'h0);

        // Ignored addresses, then two commits in one frame
        dc0 = done_cnt_a;
        cyc();
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 4'd9;
        cyc();
        wr_addr = 3'd7;
        cyc();
        wr_en = 1'b0;
        goto_k(135); commit = 1'b1; cyc(); commit = 1'b0;
        goto_k(139); commit = 1'b1; cyc(); commit = 1'b0;
        goto_k(145); @(negedge clk); chk("dbl_d5", 32'(bcd_a), 32'h8);
        goto_k(167); @(negedge clk); chk("dbl_d0", 32'(bcd_a), 32'h0);
                                     chk("dbl_cnt", 32'(done_cnt_a - dc0), 32'd1);

        // Display disabled keeps scanning
        cyc();
        disp_en = 1'b0;
        goto_k(170); @(negedge clk); chk("off_bcd5", 32'(bcd_a), 32'hF);
                                     chk("off_sel5", 32'(sel_a), 32'd5);
        goto_k(175); @(negedge clk); chk("off_bcd4", 32'(bcd_a), 32'hF);
                                     chk("off_sel4", 32'(sel_a), 32'd4);
        cyc();
        disp_en = 1'b1;

        // Reset mid-frame with a pending commit
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'd3; commit = 1'b1;
        cyc();
        wr_en = 1'b0; commit = 1'b0;
        @(negedge clk); chk("pre_rst_busy", 32'(bus_a.busy), 32'd1);
        cyc();
        reset = 1'b0;
        @(negedge clk); chk("mrst_busy", 32'(bus_a.busy), 32'd0);
                        chk("mrst_sel",  32'(sel_a), 32'd5);
                        chk("mrst_bcd",  32'(bcd_a), 32'hF);
        cyc();
        cyc();
        reset = 1'b1;
        dc0 = done_cnt_a;
        goto_k(1);  @(negedge clk); chk("mrst_d5", 32'(bcd_a), 32'h0);
        goto_k(25); @(negedge clk); chk("mrst_d5_wrap", 32'(bcd_a), 32'h0);
        goto_k(60); @(negedge clk); chk("mrst_nodone", 32'(done_cnt_a - dc0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
